// File: rtl/seg_scan_drive.sv
// Multiplexed seven-segment scan driver with per-slot dead time, tear-free
// frame-boundary updates and optional leading-zero suppression.
module seg_scan_drive #(
  parameter int unsigned DIGITS       = 4,
  parameter int unsigned SCAN_CYCLES  = 50_000,
  parameter int unsigned BLANK_CYCLES = 500
) (
  input  logic                  sclk,
  input  logic                  s_rst_n,
  input  logic                  en,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   data,
  input  logic [DIGITS-1:0]     dp,
  input  logic                  lz_blank,
  output logic [DIGITS-1:0]     sel,
  output logic [7:0]            seg,
  output logic                  frame_start
);

  localparam int unsigned CNT_W = $clog2(SCAN_CYCLES);
  localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int unsigned NIB_W = 4 * DIGITS;

  logic [CNT_W-1:0]  cnt;
  logic [IDX_W-1:0]  idx;
  logic [NIB_W-1:0]  pend_data;
  logic [DIGITS-1:0] pend_dp;
  logic              pend_valid;
  logic [NIB_W-1:0]  disp_data;
  logic [DIGITS-1:0] disp_dp;

  logic              slot_end;
  logic              boundary;
  logic              in_blank;
  logic [IDX_W-1:0]  msnz;
  logic [3:0]        nib;
  logic              dig_dp;
  logic              dig_blank;
  logic [6:0]        hex7;
  logic [DIGITS-1:0] sel_nxt;
  logic [7:0]        seg_nxt;

  assign slot_end = (cnt == CNT_W'(SCAN_CYCLES - 1));
  assign boundary = en && slot_end && (idx == IDX_W'(DIGITS - 1));
  assign in_blank = (cnt < CNT_W'(BLANK_CYCLES));

  // Current digit nibble/dp and the most-significant nonzero digit position
  always_comb begin
    nib    = 4'h0;
    dig_dp = 1'b0;
    msnz   = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx == IDX_W'(i)) begin
        nib    = disp_data[4*i +: 4];
        dig_dp = disp_dp[i];
      end
      if (i > 0 && disp_data[4*i +: 4] != 4'h0) begin
        msnz = IDX_W'(i);
      end
    end
  end

  assign dig_blank = lz_blank && (idx > msnz);

  always_comb begin
    hex7 = 7'h7F;
    case (nib)
      4'h0: hex7 = 7'h40;
      4'h1: hex7 = 7'h79;
      4'h2: hex7 = 7'h24;
      4'h3: hex7 = 7'h30;
      4'h4: hex7 = 7'h19;
      4'h5: hex7 = 7'h12;
      4'h6: hex7 = 7'h02;
      4'h7: hex7 = 7'h78;
      4'h8: hex7 = 7'h00;
      4'h9: hex7 = 7'h10;
      4'hA: hex7 = 7'h08;
      4'hB: hex7 = 7'h03;
      4'hC: hex7 = 7'h46;
      4'hD: hex7 = 7'h21;
      4'hE: hex7 = 7'h06;
      4'hF: hex7 = 7'h0E;
      default: hex7 = 7'h7F;
    endcase
  end

  always_comb begin
    sel_nxt = '1;
    seg_nxt = 8'hFF;
    if (!in_blank) begin
      sel_nxt = ~(DIGITS'(1) << idx);
      seg_nxt = {~dig_dp, dig_blank ? 7'h7F : hex7};
    end
  end

  always_ff @(posedge sclk) begin
    if (!s_rst_n) begin
      cnt         <= '0;
      idx         <= '0;
      pend_data   <= '0;
      pend_dp     <= '0;
      pend_valid  <= 1'b0;
      disp_data   <= '0;
      disp_dp     <= '0;
      sel         <= '1;
      seg         <= 8'hFF;
      frame_start <= 1'b0;
    end else begin
      frame_start <= boundary && pend_valid;

      // A load on the boundary cycle stays pending; display takes the older contents
      if (load) begin
        pend_data  <= data;
        pend_dp    <= dp;
        pend_valid <= 1'b1;
      end else if (boundary) begin
        pend_valid <= 1'b0;
      end

      if (boundary && pend_valid) begin
        disp_data <= pend_data;
        disp_dp   <= pend_dp;
      end

      if (!en) begin
        cnt <= '0;
        idx <= '0;
        sel <= '1;
        seg <= 8'hFF;
      end else begin
        sel <= sel_nxt;
        seg <= seg_nxt;
        if (slot_end) begin
          cnt <= '0;
          idx <= (idx == IDX_W'(DIGITS - 1)) ? '0 : idx + IDX_W'(1);
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_drive.sv
// Directed self-checking bench for seg_scan_drive (4 digits, 10-cycle slots, 2-cycle dead time).
module tb_seg_scan_drive;

  localparam int unsigned DIGITS = 4;
  localparam int unsigned SCAN   = 10;
  localparam int unsigned BLANK  = 2;

  logic        sclk = 1'b0;
  logic        s_rst_n;
  logic        en;
  logic        load;
  logic [15:0] data;
  logic [3:0]  dp;
  logic        lz_blank;
  logic [3:0]  sel;
  logic [7:0]  seg;
  logic        frame_start;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  always #5 sclk = ~sclk;

  seg_scan_drive #(
    .DIGITS      (DIGITS),
    .SCAN_CYCLES (SCAN),
    .BLANK_CYCLES(BLANK)
  ) dut (
    .sclk       (sclk),
    .s_rst_n    (s_rst_n),
    .en         (en),
    .load       (load),
    .data       (data),
    .dp         (dp),
    .lz_blank   (lz_blank),
    .sel        (sel),
    .seg        (seg),
    .frame_start(frame_start)
  );

  task automatic tick();
    @(posedge sclk);
    #1;
    cyc++;
  endtask

  task automatic run_to(input int t);
    while (cyc < t) tick();
  endtask

  task automatic test_reset();
    s_rst_n = 1'b0; en = 1'b0; load = 1'b0; data = '0; dp = '0; lz_blank = 1'b0;
    tick(); tick();
    n_cmp++; if (sel !== 4'hF) begin n_bad++; $display("FAIL reset_sel got %h want F", sel); end
    n_cmp++; if (seg !== 8'hFF) begin n_bad++; $display("FAIL reset_seg got %h want FF", seg); end
    n_cmp++; if (frame_start !== 1'b0) begin n_bad++; $display("FAIL reset_fs got %b want 0", frame_start); end
    s_rst_n = 1'b1; en = 1'b1; load = 1'b1; data = 16'h1234; dp = 4'h0;
    cyc = 0;
  endtask

  task automatic test_scan();
    int         ks[10] = '{3, 41, 42, 43, 50, 51, 53, 63, 73, 83};
    logic [3:0] es[10] = '{4'hE, 4'hF, 4'hF, 4'hE, 4'hE, 4'hF, 4'hD, 4'hB, 4'h7, 4'hE};
    logic [7:0] eg[10] = '{8'hC0, 8'hFF, 8'hFF, 8'h99, 8'h99, 8'hFF, 8'hB0, 8'hA4, 8'hF9, 8'h99};
    int pulses = 0;
    tick();
    load = 1'b0;
    for (int i = 0; i < 10; i++) begin
      while (cyc < ks[i]) begin
        tick();
        if (frame_start === 1'b1) pulses++;
        if (cyc == 40) begin
          n_cmp++; if (frame_start !== 1'b1) begin n_bad++; $display("FAIL scan_fs cyc=%0d got %b want 1", cyc, frame_start); end
        end
      end
      n_cmp++; if (sel !== es[i]) begin n_bad++; $display("FAIL scan_sel cyc=%0d got %h want %h", cyc, sel, es[i]); end
      n_cmp++; if (seg !== eg[i]) begin n_bad++; $display("FAIL scan_seg cyc=%0d got %h want %h", cyc, seg, eg[i]); end
    end
    n_cmp++; if (pulses != 1) begin n_bad++; $display("FAIL scan_pulses got %0d want 1", pulses); end
  endtask

  task automatic test_tear();
    int         ks[6] = '{103, 113, 123, 133, 143, 153};
    logic [3:0] es[6] = '{4'hB, 4'h7, 4'hE, 4'hD, 4'hB, 4'h7};
    logic [7:0] eg[6] = '{8'hA4, 8'hF9, 8'h8E, 8'h86, 8'hC0, 8'hC0};
    int pulses = 0;
    run_to(90);
    load = 1'b1; data = 16'hABCD;
    tick();
    load = 1'b0;
    run_to(100);
    load = 1'b1; data = 16'h00EF;
    tick();
    load = 1'b0;
    for (int i = 0; i < 6; i++) begin
      while (cyc < ks[i]) begin
        tick();
        if (frame_start === 1'b1) pulses++;
        if (cyc == 120) begin
          n_cmp++; if (frame_start !== 1'b1) begin n_bad++; $display("FAIL tear_fs cyc=%0d got %b want 1", cyc, frame_start); end
        end
      end
      n_cmp++; if (sel !== es[i]) begin n_bad++; $display("FAIL tear_sel cyc=%0d got %h want %h", cyc, sel, es[i]); end
      n_cmp++; if (seg !== eg[i]) begin n_bad++; $display("FAIL tear_seg cyc=%0d got %h want %h", cyc, seg, eg[i]); end
    end
    n_cmp++; if (pulses != 1) begin n_bad++; $display("FAIL tear_pulses got %0d want 1", pulses); end
  endtask

  task automatic test_blank();
    int         ks[6] = '{183, 193, 203, 213, 223, 233};
    logic [3:0] es[6] = '{4'hB, 4'h7, 4'hE, 4'hD, 4'hB, 4'h7};
    logic [7:0] eg[6] = '{8'hFF, 8'hFF, 8'hC0, 8'h92, 8'hFF, 8'h7F};
    int pulses = 0;
    run_to(160);
    lz_blank = 1'b1; load = 1'b1; data = 16'h0050; dp = 4'b1000;
    tick();
    load = 1'b0;
    for (int i = 0; i < 6; i++) begin
      while (cyc < ks[i]) begin
        tick();
        if (frame_start === 1'b1) pulses++;
        if (cyc == 200) begin
          n_cmp++; if (frame_start !== 1'b1) begin n_bad++; $display("FAIL blank_fs cyc=%0d got %b want 1", cyc, frame_start); end
        end
      end
      n_cmp++; if (sel !== es[i]) begin n_bad++; $display("FAIL blank_sel cyc=%0d got %h want %h", cyc, sel, es[i]); end
      n_cmp++; if (seg !== eg[i]) begin n_bad++; $display("FAIL blank_seg cyc=%0d got %h want %h", cyc, seg, eg[i]); end
    end
    n_cmp++; if (pulses != 1) begin n_bad++; $display("FAIL blank_pulses got %0d want 1", pulses); end
  endtask

  task automatic test_back_to_back();
    int         ks[4] = '{243, 253, 283, 293};
    logic [3:0] es[4] = '{4'hE, 4'hD, 4'hE, 4'hD};
    logic [7:0] eg[4] = '{8'hC0, 8'h92, 8'hF9, 8'hF9};
    int pulses = 0;
    run_to(239);
    load = 1'b1; data = 16'h1111; dp = 4'h0;
    tick();
    load = 1'b0;
    n_cmp++; if (frame_start !== 1'b0) begin n_bad++; $display("FAIL simul_fs_early got %b want 0", frame_start); end
    for (int i = 0; i < 4; i++) begin
      while (cyc < ks[i]) begin
        tick();
        if (frame_start === 1'b1) pulses++;
        if (cyc == 280) begin
          n_cmp++; if (frame_start !== 1'b1) begin n_bad++; $display("FAIL simul_fs cyc=%0d got %b want 1", cyc, frame_start); end
        end
      end
      n_cmp++; if (sel !== es[i]) begin n_bad++; $display("FAIL simul_sel cyc=%0d got %h want %h", cyc, sel, es[i]); end
      n_cmp++; if (seg !== eg[i]) begin n_bad++; $display("FAIL simul_seg cyc=%0d got %h want %h", cyc, seg, eg[i]); end
    end
    n_cmp++; if (pulses != 1) begin n_bad++; $display("FAIL simul_pulses got %0d want 1", pulses); end
  endtask

  task automatic test_enable();
    run_to(295);
    en = 1'b0;
    tick();
    n_cmp++; if (sel !== 4'hF) begin n_bad++; $display("FAIL en_off_sel got %h want F", sel); end
    n_cmp++; if (seg !== 8'hFF) begin n_bad++; $display("FAIL en_off_seg got %h want FF", seg); end
    load = 1'b1; data = 16'h2222;
    tick();
    load = 1'b0;
    tick(); tick();
    n_cmp++; if (frame_start !== 1'b0) begin n_bad++; $display("FAIL en_off_fs got %b want 0", frame_start); end
    en = 1'b1;
    cyc = 0;
    tick(); tick();
    n_cmp++; if (sel !== 4'hF || seg !== 8'hFF) begin n_bad++; $display("FAIL en_dead sel=%h seg=%h want F/FF", sel, seg); end
    tick();
    n_cmp++; if (sel !== 4'hE) begin n_bad++; $display("FAIL en_restart_sel got %h want E", sel); end
    n_cmp++; if (seg !== 8'hF9) begin n_bad++; $display("FAIL en_restart_seg got %h want F9", seg); end
    run_to(40);
    n_cmp++; if (frame_start !== 1'b1) begin n_bad++; $display("FAIL en_fs got %b want 1", frame_start); end
    run_to(43);
    n_cmp++; if (seg !== 8'hA4) begin n_bad++; $display("FAIL en_pending_seg got %h want A4", seg); end
  endtask

  task automatic test_midreset();
    int pulses = 0;
    run_to(55);
    s_rst_n = 1'b0; load = 1'b1; data = 16'h3333; dp = 4'hF;
    tick();
    n_cmp++; if (sel !== 4'hF) begin n_bad++; $display("FAIL rst_sel got %h want F", sel); end
    n_cmp++; if (seg !== 8'hFF) begin n_bad++; $display("FAIL rst_seg got %h want FF", seg); end
    n_cmp++; if (frame_start !== 1'b0) begin n_bad++; $display("FAIL rst_fs got %b want 0", frame_start); end
    s_rst_n = 1'b1; load = 1'b0; lz_blank = 1'b1;
    cyc = 0;
    run_to(3);
    n_cmp++; if (sel !== 4'hE || seg !== 8'hC0) begin n_bad++; $display("FAIL rst_d0 sel=%h seg=%h want E/C0", sel, seg); end
    run_to(13);
    n_cmp++; if (sel !== 4'hD || seg !== 8'hFF) begin n_bad++; $display("FAIL rst_d1 sel=%h seg=%h want D/FF", sel, seg); end
    while (cyc < 43) begin
      tick();
      if (frame_start === 1'b1) pulses++;
    end
    n_cmp++; if (pulses != 0) begin n_bad++; $display("FAIL rst_pulses got %0d want 0", pulses); end
    n_cmp++; if (sel !== 4'hE || seg !== 8'hC0) begin n_bad++; $display("FAIL rst_d0b sel=%h seg=%h want E/C0", sel, seg); end
    run_to(45);
    lz_blank = 1'b0;
    run_to(53);
    n_cmp++; if (sel !== 4'hD || seg !== 8'hC0) begin n_bad++; $display("FAIL rst_nolz sel=%h seg=%h want D/C0", sel, seg); end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_tear();
    test_blank();
    test_back_to_back();
    test_enable();
    test_midreset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

endmodule
